packet_rx_engine: RTL and testbench

PACKET_RX_ENGINE -- requirements
Module: packet_rx_engine

---
 rtl/cherry_dma_pkg.sv | 31 +++
 rtl/rx_gap_timer.sv | 30 +++
 rtl/packet_rx_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_packet_rx_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cherry_dma_pkg.sv
// Shared encodings for the DMA receive path: packet types,
// header field positions and the receive state enumeration.
package cherry_dma_pkg;

    localparam logic [1:0] PKT_RSVD   = 2'd0;
    localparam logic [1:0] PKT_UPLOAD = 2'd1;
    localparam logic [1:0] PKT_ENQ    = 2'd2;
    localparam logic [1:0] PKT_READ   = 2'd3;

    localparam int HDR_TYPE_LSB = 0;
    localparam int HDR_TYPE_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP_ADDR,
        ST_UP_DATA,
        ST_ENQ,
        ST_TILE,
        ST_DISCARD,
        ST_RESYNC
    } rx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Counts consecutive idle cycles; expire fires on the
// TIMEOUT_CYCLES-th tick after the last load.
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expire = tick && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load || expire) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/packet_rx_engine.sv
// Byte-stream packet receiver: decodes headers and emits
// program-upload words, enqueue descriptors and read tiles.
module packet_rx_engine
    import cherry_dma_pkg::*;
#(
    parameter int TILE_BYTES     = 36,
    parameter int ENQ_BYTES      = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_interrupt,
    input  logic [7:0]              rx_data,
    output logic                    prog_valid,
    input  logic                    prog_ready,
    output logic [15:0]             prog_addr,
    output logic [15:0]             prog_dat,
    output logic                    enq_valid,
    input  logic                    enq_ready,
    output logic [8*ENQ_BYTES-1:0]  enq_dat,
    output logic                    tile_valid,
    input  logic                    tile_ready,
    output logic [8*TILE_BYTES-1:0] tile_dat,
    output logic                    err_pulse,
    output logic [7:0]              err_count
);

    localparam int CW =
        $clog2(max3(TILE_BYTES, ENQ_BYTES, 64) + 1);

    rx_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0] tiles, tiles_nxt;
    logic phase, phase_nxt;
    logic [15:0] addr, addr_nxt;
    logic [7:0] hi_byte;
    logic [8*ENQ_BYTES-1:0] enq_sh, enq_nxt;
    logic [8*TILE_BYTES-1:0] tile_sh, tile_nxt;

    logic [1:0] hdr_type;
    logic [5:0] hdr_len;
    logic pending, overrun, take, expire, gap_load, err;
    logic prog_fire, enq_fire, tile_fire;

    assign hdr_type = rx_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
    assign hdr_len  = rx_data[HDR_LEN_MSB:HDR_LEN_LSB];

    assign pending = (prog_valid && !prog_ready)
                  || (enq_valid && !enq_ready)
                  || (tile_valid && !tile_ready);

    // RESYNC already swallows bytes, so no overrun is charged there
    assign overrun = rx_interrupt && pending
                  && (state != ST_RESYNC);
    assign take = rx_interrupt && !overrun;

    assign gap_load = rx_interrupt || (state == ST_IDLE);

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap (
        .clk   (clk),
        .reset (reset),
        .load  (gap_load),
        .tick  (!gap_load),
        .expire(expire)
    );

    always_comb begin
        enq_nxt       = enq_sh << 8;
        enq_nxt[7:0]  = rx_data;
        tile_nxt      = tile_sh << 8;
        tile_nxt[7:0] = rx_data;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tiles_nxt = tiles;
        phase_nxt = phase;
        addr_nxt  = addr;
        err       = 1'b0;
        prog_fire = 1'b0;
        enq_fire  = 1'b0;
        tile_fire = 1'b0;
        if (expire) begin
            state_nxt = ST_IDLE;
            err       = (state != ST_RESYNC);
        end else if (overrun) begin
            state_nxt = ST_RESYNC;
            err       = 1'b1;
        end else if (take) begin
            unique case (state)
                ST_IDLE: begin
                    phase_nxt = 1'b0;
                    cnt_nxt   = CW'(hdr_len);
                    unique case (hdr_type)
                        PKT_UPLOAD: begin
                            if (hdr_len[0] || hdr_len < 6'd4) begin
                                err = 1'b1;
                                if (hdr_len != 6'd0)
                                    state_nxt = ST_DISCARD;
                            end else begin
                                state_nxt = ST_UP_ADDR;
                            end
                        end
                        PKT_ENQ: begin
                            cnt_nxt   = CW'(ENQ_BYTES);
                            state_nxt = ST_ENQ;
                        end
                        PKT_READ: begin
                            cnt_nxt   = CW'(TILE_BYTES);
                            tiles_nxt = (hdr_len == 6'd0)
                                      ? 6'd1 : hdr_len;
                            state_nxt = ST_TILE;
                        end
                        default: begin
                            err = 1'b1;
                            if (hdr_len != 6'd0)
                                state_nxt = ST_DISCARD;
                        end
                    endcase
                end
                ST_UP_ADDR: begin
                    cnt_nxt   = cnt - CW'(1);
                    phase_nxt = !phase;
                    addr_nxt  = {addr[7:0], rx_data};
                    if (phase)
                        state_nxt = ST_UP_DATA;
                end
                ST_UP_DATA: begin
                    cnt_nxt   = cnt - CW'(1);
                    phase_nxt = !phase;
                    if (phase) begin
                        prog_fire = 1'b1;
                        addr_nxt  = addr + 16'd1;
                    end
                    if (cnt == CW'(1))
                        state_nxt = ST_IDLE;
                end
                ST_ENQ: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        enq_fire  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_TILE: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        tile_fire = 1'b1;
                        cnt_nxt   = CW'(TILE_BYTES);
                        tiles_nxt = tiles - 6'd1;
                        if (tiles == 6'd1)
                            state_nxt = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1))
                        state_nxt = ST_IDLE;
                end
                ST_RESYNC: begin
                    state_nxt = ST_RESYNC;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tiles      <= '0;
            phase      <= 1'b0;
            addr       <= '0;
            hi_byte    <= '0;
            enq_sh     <= '0;
            tile_sh    <= '0;
            prog_valid <= 1'b0;
            prog_addr  <= '0;
            prog_dat   <= '0;
            enq_valid  <= 1'b0;
            enq_dat    <= '0;
            tile_valid <= 1'b0;
            tile_dat   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tiles <= tiles_nxt;
            phase <= phase_nxt;
            addr  <= addr_nxt;
            if (take && state == ST_UP_DATA && !phase)
                hi_byte <= rx_data;
            if (take && state == ST_ENQ)
                enq_sh <= enq_nxt;
            if (take && state == ST_TILE)
                tile_sh <= tile_nxt;

            if (prog_fire) begin
                prog_valid <= 1'b1;
                prog_addr  <= addr;
                prog_dat   <= {hi_byte, rx_data};
            end else if (prog_ready) begin
                prog_valid <= 1'b0;
            end

            if (enq_fire) begin
                enq_valid <= 1'b1;
                enq_dat   <= enq_nxt;
            end else if (enq_ready) begin
                enq_valid <= 1'b0;
            end

            if (tile_fire) begin
                tile_valid <= 1'b1;
                tile_dat   <= tile_nxt;
            end else if (tile_ready) begin
                tile_valid <= 1'b0;
            end

            err_pulse <= err;
            if (err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_packet_rx_engine.sv
// Randomized packet-level bench for packet_rx_engine with a
// queue-based reference model of expected outputs and errors.
module tb_packet_rx_engine;

    localparam int TB = 36;
    localparam int EB = 5;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_interrupt = 1'b0;
    logic [7:0] rx_data = '0;
    logic prog_ready = 1'b1;
    logic enq_ready = 1'b1;
    logic tile_ready = 1'b1;
    logic prog_valid, enq_valid, tile_valid, err_pulse;
    logic [15:0] prog_addr, prog_dat;
    logic [8*EB-1:0] enq_dat;
    logic [8*TB-1:0] tile_dat;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    packet_rx_engine #(
        .TILE_BYTES(TB),
        .ENQ_BYTES(EB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_interrupt(rx_interrupt),
        .rx_data(rx_data),
        .prog_valid(prog_valid),
        .prog_ready(prog_ready),
        .prog_addr(prog_addr),
        .prog_dat(prog_dat),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_dat(enq_dat),
        .tile_valid(tile_valid),
        .tile_ready(tile_ready),
        .tile_dat(tile_dat),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    int n_tests = 0;
    int n_fail = 0;
    int exp_err = 0;
    int pulses = 0;
    bit rand_mode = 0;
    bit no_wait = 0;

    logic [31:0] prog_q[$];
    logic [8*EB-1:0] enq_q[$];
    logic [8*TB-1:0] tile_q[$];

    task automatic check(input string tag,
                         input logic [8*TB-1:0] got,
                         input logic [8*TB-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_err();
        return (exp_err > 255) ? 255 : exp_err;
    endfunction

    function automatic bit stall();
        return (prog_valid && !prog_ready)
            || (enq_valid && !enq_ready)
            || (tile_valid && !tile_ready);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (prog_valid) begin
                if (prog_q.size() == 0)
                    check("prog_unexpected", prog_valid, 0);
                else begin
                    check("prog", {prog_addr, prog_dat}, prog_q[0]);
                    if (prog_ready) void'(prog_q.pop_front());
                end
            end
            if (enq_valid) begin
                if (enq_q.size() == 0)
                    check("enq_unexpected", enq_valid, 0);
                else begin
                    check("enq", enq_dat, enq_q[0]);
                    if (enq_ready) void'(enq_q.pop_front());
                end
            end
            if (tile_valid) begin
                if (tile_q.size() == 0)
                    check("tile_unexpected", tile_valid, 0);
                else begin
                    check("tile", tile_dat, tile_q[0]);
                    if (tile_ready) void'(tile_q.pop_front());
                end
            end
            if (err_pulse) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            prog_ready = 1'($urandom_range(0, 1));
            enq_ready  = 1'($urandom_range(0, 1));
            tile_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        if (!no_wait) begin
            while (stall() && w < 200) begin
                tick();
                w++;
            end
            if (w >= 200) check("stall_timeout", w, 0);
        end
        rx_data = b;
        rx_interrupt = 1'b1;
        tick();
        rx_interrupt = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] q[$]);
        foreach (q[i]) begin
            if (rand_mode) repeat ($urandom_range(0, 2)) tick();
            send_byte(q[i]);
        end
    endtask

    task automatic pkt_upload(input logic [5:0] len,
                              input logic [15:0] base);
        logic [7:0] q[$];
        logic [15:0] w;
        q.push_back({len, 2'b01});
        if (len[0] || len < 6'd4) begin
            exp_err++;
            for (int i = 0; i < len; i++)
                q.push_back(8'($urandom));
        end else begin
            q.push_back(base[15:8]);
            q.push_back(base[7:0]);
            for (int i = 0; i < (len - 2) / 2; i++) begin
                w = 16'($urandom);
                q.push_back(w[15:8]);
                q.push_back(w[7:0]);
                prog_q.push_back({16'(base + 16'(i)), w});
            end
        end
        send_pkt(q);
    endtask

    task automatic pkt_enq(input logic [5:0] len);
        logic [7:0] q[$];
        logic [7:0] b;
        logic [8*EB-1:0] e;
        e = '0;
        q.push_back({len, 2'b10});
        for (int i = 0; i < EB; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            e = {e[8*EB-9:0], b};
        end
        enq_q.push_back(e);
        send_pkt(q);
    endtask

    task automatic pkt_read(input logic [5:0] len, input bit seq);
        logic [7:0] q[$];
        logic [7:0] b;
        logic [8*TB-1:0] t;
        int n, k;
        k = 0;
        n = (len == 0) ? 1 : int'(len);
        q.push_back({len, 2'b11});
        for (int j = 0; j < n; j++) begin
            t = '0;
            for (int i = 0; i < TB; i++) begin
                b = seq ? 8'(k) : 8'($urandom);
                k++;
                q.push_back(b);
                t = {t[8*TB-9:0], b};
            end
            tile_q.push_back(t);
        end
        send_pkt(q);
    endtask

    task automatic pkt_rsvd(input logic [5:0] len);
        logic [7:0] q[$];
        exp_err++;
        q.push_back({len, 2'b00});
        for (int i = 0; i < len; i++)
            q.push_back(8'($urandom));
        send_pkt(q);
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        if (!rand_mode) begin
            prog_ready = 1'b1;
            enq_ready  = 1'b1;
            tile_ready = 1'b1;
        end
        while ((prog_q.size() + enq_q.size() + tile_q.size()) != 0
               && w < 500) begin
            tick();
            w++;
        end
        tick();
        tick();
        check({tag, "_drain"},
              prog_q.size() + enq_q.size() + tile_q.size(), 0);
        check({tag, "_err_count"}, err_count, sat_err());
        check({tag, "_err_pulses"}, pulses, exp_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_prog_valid"}, prog_valid, 0);
        check({tag, "_enq_valid"}, enq_valid, 0);
        check({tag, "_tile_valid"}, tile_valid, 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_prog_data"}, {prog_addr, prog_dat}, 0);
        check({tag, "_enq_dat"}, enq_dat, 0);
        check({tag, "_tile_dat"}, tile_dat, 0);
    endtask

    initial begin
        logic [7:0] hdr;
        int sel;

        #2;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();

        prog_q.push_back({16'h1234, 16'hABCD});
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        drain("upload");

        pkt_read(6'd2, 1'b1);
        drain("read_burst");

        enq_ready = 1'b0;
        enq_q.push_back(40'h0102030405);
        send_byte(8'h02);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        repeat (10) tick();
        check("enq_held", enq_valid, 1);
        enq_ready = 1'b1;
        tick();
        check("enq_cleared", enq_valid, 0);
        drain("enq_backpressure");

        send_byte(8'h03);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        exp_err++;
        repeat (TO + 5) tick();
        check("timeout_err_count", err_count, 1);
        pkt_enq(6'd0);
        drain("timeout");

        tile_ready = 1'b0;
        pkt_read(6'd0, 1'b0);
        tick();
        no_wait = 1;
        send_byte(8'hEE);
        no_wait = 0;
        exp_err++;
        tick();
        check("overrun_err_count", err_count, sat_err());
        check("overrun_tile_held", tile_valid, 1);
        tile_ready = 1'b1;
        tick();
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (TO + 5) tick();
        pkt_enq(6'd7);
        drain("overrun");

        rand_mode = 1;
        for (int p = 0; p < 60; p++) begin
            sel = $urandom_range(0, 9);
            hdr = 8'($urandom);
            if (sel < 3)
                pkt_upload(6'($urandom_range(0, 20)), hdr * 16'd257);
            else if (sel < 6)
                pkt_enq(hdr[7:2]);
            else if (sel < 8)
                pkt_read(6'($urandom_range(0, 2)), 1'b0);
            else
                pkt_rsvd(6'($urandom_range(0, 8)));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain("random");
        rand_mode = 0;
        prog_ready = 1'b1;
        enq_ready  = 1'b1;
        tile_ready = 1'b1;

        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h34);
        #2;
        reset = 1'b0;
        #1;
        check_zero("midreset");
        prog_q.delete();
        enq_q.delete();
        tile_q.delete();
        exp_err = 0;
        pulses = 0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        pkt_enq(6'd1);
        drain("after_reset");

        for (int i = 0; i < 260; i++) send_byte(8'h00);
        exp_err += 260;
        drain("saturate");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
